// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754 adder/subtractor, one op in flight.
// Ports: clk, rst (async, active-low), input_a/b/op/rm/stb/ack in, output_z/flags/z_stb/z_ack out.
module fp_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic [EXP_W+MAN_W:0]   input_b,
  input  logic                   input_op,
  input  logic [1:0]             input_rm,
  input  logic                   input_stb,
  output logic                   input_ack,
  output logic [EXP_W+MAN_W:0]   output_z,
  output logic [3:0]             output_flags,
  output logic                   output_z_stb,
  input  logic                   output_z_ack
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 4;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] EMAX = EW'(BIAS);
  localparam logic [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic [EW-1:0] E_ONE  = EW'(1);
  localparam logic [EW-1:0] SH_MAX = EW'(MW);

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  localparam logic [3:0] S_GET     = 4'd0;
  localparam logic [3:0] S_UNPACK  = 4'd1;
  localparam logic [3:0] S_SPECIAL = 4'd2;
  localparam logic [3:0] S_ALIGN   = 4'd3;
  localparam logic [3:0] S_ADD     = 4'd4;
  localparam logic [3:0] S_NORM_L  = 4'd5;
  localparam logic [3:0] S_NORM_R  = 4'd6;
  localparam logic [3:0] S_ROUND   = 4'd7;
  localparam logic [3:0] S_PACK    = 4'd8;
  localparam logic [3:0] S_PUT     = 4'd9;

  logic [3:0]   state_q, state_d;
  logic         in_ack_q, in_ack_d;
  logic         z_stb_q, z_stb_d;
  logic [W-1:0] z_q, z_d;
  logic [3:0]   flags_q, flags_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]   rm_q, rm_d;
  logic         a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic         inx_q, inx_d;

  logic signed [EW-1:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic [MW-1:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;

  // raw operand fields (b already carries the op-adjusted sign)
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;

  assign a_exp  = a_q[W-2 -: EXP_W];
  assign b_exp  = b_q[W-2 -: EXP_W];
  assign a_frac = a_q[MAN_W-1:0];
  assign b_frac = b_q[MAN_W-1:0];
  assign a_nan  = (&a_exp) && (|a_frac);
  assign b_nan  = (&b_exp) && (|b_frac);
  assign a_inf  = (&a_exp) && !(|a_frac);
  assign b_inf  = (&b_exp) && !(|b_frac);
  assign a_snan = a_nan && !a_frac[MAN_W-1];
  assign b_snan = b_nan && !b_frac[MAN_W-1];

  // special-case resolution
  logic         sp_hit;
  logic [W-1:0] sp_z;
  logic [3:0]   sp_f;

  always_comb begin
    sp_hit = 1'b1;
    sp_z   = QNAN;
    sp_f   = 4'b0000;
    if (a_nan || b_nan) begin
      sp_f = {a_snan | b_snan, 3'b000};
    end else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) begin
      sp_f = 4'b1000;
    end else if (a_inf) begin
      sp_z = a_q;
    end else if (b_inf) begin
      sp_z = b_q;
    end else begin
      sp_hit = 1'b0;
    end
  end

  // alignment: shift the smaller-exponent mantissa, sticky-OR lost bits
  logic          a_big;
  logic [EW-1:0] ediff, shamt;
  logic [MW-1:0] sm_in, sm_out;
  logic          lost;

  always_comb begin
    a_big  = a_e_q > b_e_q;
    ediff  = a_big ? (a_e_q - b_e_q) : (b_e_q - a_e_q);
    shamt  = (ediff > SH_MAX) ? SH_MAX : ediff;
    sm_in  = a_big ? b_m_q : a_m_q;
    lost   = |(sm_in & ~({MW{1'b1}} << shamt));
    sm_out = (sm_in >> shamt) | {{(MW-1){1'b0}}, lost};
  end

  // magnitude add/subtract
  logic [MW:0] sum;
  logic        same, a_ge, sum_s;

  always_comb begin
    same  = a_s_q == b_s_q;
    a_ge  = a_m_q >= b_m_q;
    sum   = {1'b0, a_m_q} + {1'b0, b_m_q};
    sum_s = a_s_q;
    if (!same) begin
      if (a_ge) begin
        sum   = {1'b0, a_m_q} - {1'b0, b_m_q};
      end else begin
        sum   = {1'b0, b_m_q} - {1'b0, a_m_q};
        sum_s = b_s_q;
      end
      // exact cancellation: sign depends only on rounding direction
      if (sum == '0) sum_s = (rm_q == RM_RDN);
    end
  end

  // rounding
  logic [MAN_W:0]   sig;
  logic             g_b, r_b, s_b, inx, inc;
  logic [MAN_W+1:0] rsum;

  always_comb begin
    sig = z_m_q[MW-1:3];
    g_b = z_m_q[2];
    r_b = z_m_q[1];
    s_b = z_m_q[0];
    inx = g_b | r_b | s_b;
    unique case (rm_q)
      RM_RNE:  inc = g_b & (r_b | s_b | sig[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = inx & !z_s_q;
      default: inc = inx & z_s_q;
    endcase
    rsum = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
  end

  // packing
  logic [EXP_W-1:0] pk_exp;
  logic [W-1:0]     pk_z, pk_inf, pk_max;
  logic [3:0]       pk_f;

  always_comb begin
    pk_exp = sig[MAN_W] ? EXP_W'(z_e_q + E_BIAS) : '0;
    pk_inf = {z_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    pk_max = {z_s_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    pk_z   = {z_s_q, pk_exp, sig[MAN_W-1:0]};
    pk_f   = {2'b00, !sig[MAN_W] & inx_q, inx_q};
    if (z_e_q > EMAX) begin
      pk_f = 4'b0101;
      unique case (rm_q)
        RM_RNE:  pk_z = pk_inf;
        RM_RTZ:  pk_z = pk_max;
        RM_RUP:  pk_z = z_s_q ? pk_max : pk_inf;
        default: pk_z = z_s_q ? pk_inf : pk_max;
      endcase
    end
  end

  // next-state
  always_comb begin
    state_d  = state_q;
    in_ack_d = in_ack_q;
    z_stb_d  = z_stb_q;
    z_d      = z_q;
    flags_d  = flags_q;
    a_d      = a_q;
    b_d      = b_q;
    rm_d     = rm_q;
    a_s_d    = a_s_q;
    b_s_d    = b_s_q;
    z_s_d    = z_s_q;
    a_e_d    = a_e_q;
    b_e_d    = b_e_q;
    z_e_d    = z_e_q;
    a_m_d    = a_m_q;
    b_m_d    = b_m_q;
    z_m_d    = z_m_q;
    inx_d    = inx_q;
    unique case (state_q)
      S_GET: begin
        if (!in_ack_q) begin
          in_ack_d = 1'b1;
        end else if (input_stb) begin
          a_d      = input_a;
          b_d      = {input_b[W-1] ^ input_op, input_b[W-2:0]};
          rm_d     = input_rm;
          flags_d  = 4'b0000;
          in_ack_d = 1'b0;
          state_d  = S_UNPACK;
        end
      end
      S_UNPACK: begin
        a_s_d   = a_q[W-1];
        b_s_d   = b_q[W-1];
        a_e_d   = (a_exp == '0) ? EMIN : ({2'b00, a_exp} - E_BIAS);
        b_e_d   = (b_exp == '0) ? EMIN : ({2'b00, b_exp} - E_BIAS);
        a_m_d   = {|a_exp, a_frac, 3'b000};
        b_m_d   = {|b_exp, b_frac, 3'b000};
        state_d = S_SPECIAL;
      end
      S_SPECIAL: begin
        if (sp_hit) begin
          z_d     = sp_z;
          flags_d = sp_f;
          z_stb_d = 1'b1;
          state_d = S_PUT;
        end else begin
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (a_big) begin
          b_m_d = sm_out;
          z_e_d = a_e_q;
        end else begin
          a_m_d = sm_out;
          z_e_d = b_e_q;
        end
        state_d = S_ADD;
      end
      S_ADD: begin
        z_s_d = sum_s;
        if (sum[MW]) begin
          z_m_d = sum[MW:1] | {{(MW-1){1'b0}}, sum[0]};
          z_e_d = z_e_q + E_ONE;
        end else begin
          z_m_d = sum[MW-1:0];
        end
        state_d = S_NORM_L;
      end
      S_NORM_L: begin
        // a zero result is left alone so it cannot walk the whole range
        if (!z_m_q[MW-1] && (z_e_q > EMIN) && (|z_m_q)) begin
          z_m_d = z_m_q << 1;
          z_e_d = z_e_q - E_ONE;
        end else begin
          state_d = S_NORM_R;
        end
      end
      S_NORM_R: begin
        if (z_e_q < EMIN) begin
          z_m_d = (z_m_q >> 1) | {{(MW-1){1'b0}}, z_m_q[0]};
          z_e_d = z_e_q + E_ONE;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        inx_d = inx;
        if (rsum[MAN_W+1]) begin
          z_m_d = {rsum[MAN_W+1:1], 3'b000};
          z_e_d = z_e_q + E_ONE;
        end else begin
          z_m_d = {rsum[MAN_W:0], 3'b000};
        end
        state_d = S_PACK;
      end
      S_PACK: begin
        z_d     = pk_z;
        flags_d = pk_f;
        z_stb_d = 1'b1;
        state_d = S_PUT;
      end
      S_PUT: begin
        if (output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = S_GET;
        end
      end
      default: state_d = S_GET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_GET;
      in_ack_q <= 1'b0;
      z_stb_q  <= 1'b0;
      z_q      <= '0;
      flags_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rm_q     <= '0;
      a_s_q    <= 1'b0;
      b_s_q    <= 1'b0;
      z_s_q    <= 1'b0;
      a_e_q    <= '0;
      b_e_q    <= '0;
      z_e_q    <= '0;
      a_m_q    <= '0;
      b_m_q    <= '0;
      z_m_q    <= '0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ack_q <= in_ack_d;
      z_stb_q  <= z_stb_d;
      z_q      <= z_d;
      flags_q  <= flags_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rm_q     <= rm_d;
      a_s_q    <= a_s_d;
      b_s_q    <= b_s_d;
      z_s_q    <= z_s_d;
      a_e_q    <= a_e_d;
      b_e_q    <= b_e_d;
      z_e_q    <= z_e_d;
      a_m_q    <= a_m_d;
      b_m_q    <= b_m_d;
      z_m_q    <= z_m_d;
      inx_q    <= inx_d;
    end
  end

  assign input_ack    = in_ack_q;
  assign output_z     = z_q;
  assign output_flags = flags_q;
  assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Scoreboard bench for fp_addsub: single and half precision instances.
// Directed vectors with hand-computed results.
module tb_fp_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32 = 1'b1, rst16 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, z32;
  logic [15:0] a16 = '0, b16 = '0, z16;
  logic        op32 = 0, op16 = 0;
  logic [1:0]  rm32 = '0, rm16 = '0;
  logic        stb32 = 0, stb16 = 0;
  logic        iack32, iack16, zstb32, zstb16;
  logic        zack32 = 0, zack16 = 0;
  logic [3:0]  f32, f16;

  fp_addsub u32 (
    .clk(clk), .rst(rst32),
    .input_a(a32), .input_b(b32), .input_op(op32), .input_rm(rm32),
    .input_stb(stb32), .input_ack(iack32),
    .output_z(z32), .output_flags(f32),
    .output_z_stb(zstb32), .output_z_ack(zack32)
  );

  fp_addsub #(.EXP_W(5), .MAN_W(10)) u16 (
    .clk(clk), .rst(rst16),
    .input_a(a16), .input_b(b16), .input_op(op16), .input_rm(rm16),
    .input_stb(stb16), .input_ack(iack16),
    .output_z(z16), .output_flags(f16),
    .output_z_stb(zstb16), .output_z_ack(zack16)
  );

  typedef struct {
    logic [31:0] z;
    logic [3:0]  f;
    string       nm;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int   dly32 = 1, dly16 = 1;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [35:0] act,
                     input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic score(input bit h, input logic [31:0] z,
                       input logic [3:0] f);
    exp_t e;
    int   sz;
    sz = h ? q16.size() : q32.size();
    if (sz == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_output: got z=%h flags=%h", z, f);
    end else begin
      if (h) e = q16.pop_front();
      else   e = q32.pop_front();
      chk({e.nm, "/z"}, {4'h0, z}, {4'h0, e.z});
      chk({e.nm, "/flags"}, {32'h0, f}, {32'h0, e.f});
    end
  endtask

  // monitors: compare on first sight of stb, then hold for dly cycles
  initial begin : mon32
    int held;
    logic [35:0] first;
    held = 0;
    first = '0;
    forever begin
      @(negedge clk);
      if (zstb32) begin
        if (held == 0) begin
          score(1'b0, z32, f32);
          first = {z32, f32};
        end else begin
          chk("hold32", {z32, f32}, first);
        end
        held++;
        zack32 = (held >= dly32);
      end else begin
        held = 0;
        zack32 = 1'b0;
      end
    end
  end

  initial begin : mon16
    int held;
    logic [35:0] first;
    held = 0;
    first = '0;
    forever begin
      @(negedge clk);
      if (zstb16) begin
        if (held == 0) begin
          score(1'b1, {16'h0, z16}, f16);
          first = {16'h0, z16, f16};
        end else begin
          chk("hold16", {16'h0, z16, f16}, first);
        end
        held++;
        zack16 = (held >= dly16);
      end else begin
        held = 0;
        zack16 = 1'b0;
      end
    end
  end

  task automatic drive(input bit h, input logic [31:0] a, b,
                       input logic op, input logic [1:0] rm, input bit s);
    if (h) begin
      a16 = a[15:0]; b16 = b[15:0]; op16 = op; rm16 = rm; stb16 = s;
    end else begin
      a32 = a; b32 = b; op32 = op; rm32 = rm; stb32 = s;
    end
  endtask

  function automatic logic iack(input bit h);
    return h ? iack16 : iack32;
  endfunction

  function automatic logic zstb(input bit h);
    return h ? zstb16 : zstb32;
  endfunction

  task automatic run(input bit h, input logic [31:0] a, b,
                     input logic op, input logic [1:0] rm,
                     input logic [31:0] ez, input logic [3:0] ef,
                     input int dly, input string nm);
    exp_t e;
    int   n, lat, bound;
    bit   ack_seen;
    bound = h ? 20 : 33;
    e.z = ez; e.f = ef; e.nm = nm;
    if (h) begin q16.push_back(e); dly16 = dly; end
    else   begin q32.push_back(e); dly32 = dly; end
    @(negedge clk);
    drive(h, a, b, op, rm, 1'b1);
    n = 0;
    while (!iack(h) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "/in_ack"}, {35'h0, iack(h)}, 36'h1);
    if (!iack(h)) begin
      drive(h, a, b, op, rm, 1'b0);
      if (h) void'(q16.pop_back());
      else   void'(q32.pop_back());
      return;
    end
    @(posedge clk);
    #1 drive(h, a, b, op, rm, 1'b0);
    lat = 0;
    ack_seen = 0;
    while (!zstb(h) && lat < 60) begin
      if (iack(h)) ack_seen = 1;
      @(posedge clk);
      lat++;
      #1;
    end
    n_tests++;
    if (lat > bound) begin
      n_fail++;
      $display("FAIL %s/latency: got %0d cycles limit %0d", nm, lat, bound);
    end
    chk({nm, "/ack_low"}, {35'h0, ack_seen}, 36'h0);
    n = 0;
    while (zstb(h) && n < 60) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk({nm, "/stb_drop"}, {35'h0, zstb(h)}, 36'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    #1 rst32 = 1'b0; rst16 = 1'b0;
    #2;
    chk("rst32", {iack32, zstb32, z32, f32[1:0]}, 36'h0);
    chk("rst32_flags", {32'h0, f32}, 36'h0);
    chk("rst16", {18'h0, iack16, zstb16, z16}, 36'h0);
    chk("rst16_flags", {32'h0, f16}, 36'h0);
    repeat (2) @(negedge clk);
    rst32 = 1'b1; rst16 = 1'b1;

    run(0, 32'h3F800000, 32'h3F800000, 0, 2'd0, 32'h40000000, 4'h0, 3, "one_plus_one");
    run(0, 32'h3F800000, 32'h3F800000, 1, 2'd0, 32'h00000000, 4'h0, 1, "sub_rne");
    run(0, 32'h3F800000, 32'h3F800000, 1, 2'd3, 32'h80000000, 4'h0, 1, "sub_rdn");
    run(0, 32'h7F800000, 32'hFF800000, 0, 2'd0, 32'h7FC00000, 4'h8, 1, "inf_minus_inf");
    run(0, 32'h7F800000, 32'h7F800000, 1, 2'd0, 32'h7FC00000, 4'h8, 1, "inf_sub_inf");
    run(0, 32'h7F800001, 32'h3F800000, 0, 2'd0, 32'h7FC00000, 4'h8, 1, "snan");
    run(0, 32'h7FC00000, 32'h3F800000, 0, 2'd0, 32'h7FC00000, 4'h0, 1, "qnan");
    run(0, 32'h7F800000, 32'h3F800000, 0, 2'd0, 32'h7F800000, 4'h0, 1, "inf_single");
    run(0, 32'h3F800000, 32'h7F800000, 1, 2'd0, 32'hFF800000, 4'h0, 1, "one_sub_inf");
    run(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'd0, 32'h7F800000, 4'h5, 1, "ovf_rne");
    run(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'd1, 32'h7F7FFFFF, 4'h5, 2, "ovf_rtz");
    run(0, 32'hFF7FFFFF, 32'hFF7FFFFF, 0, 2'd2, 32'hFF7FFFFF, 4'h5, 1, "ovf_rup_neg");
    run(0, 32'hFF7FFFFF, 32'hFF7FFFFF, 0, 2'd3, 32'hFF800000, 4'h5, 1, "ovf_rdn_neg");
    run(0, 32'h3F800000, 32'h33800000, 0, 2'd0, 32'h3F800000, 4'h1, 1, "half_ulp_rne");
    run(0, 32'h3F800000, 32'h33800000, 0, 2'd2, 32'h3F800001, 4'h1, 1, "half_ulp_rup");
    run(0, 32'h3F800000, 32'h33800000, 0, 2'd1, 32'h3F800000, 4'h1, 1, "half_ulp_rtz");
    run(0, 32'h3F800001, 32'h33800000, 0, 2'd0, 32'h3F800002, 4'h1, 1, "tie_even");
    run(0, 32'h00000001, 32'h00000001, 0, 2'd0, 32'h00000002, 4'h0, 1, "denorm");
    run(0, 32'h007FFFFF, 32'h00000001, 0, 2'd0, 32'h00800000, 4'h0, 1, "denorm_to_norm");
    run(0, 32'h40400000, 32'h3F800000, 1, 2'd0, 32'h40000000, 4'h0, 1, "three_sub_one");
    run(0, 32'h80000000, 32'h80000000, 0, 2'd0, 32'h80000000, 4'h0, 1, "negzero_sum");
    run(0, 32'h00000000, 32'h80000000, 0, 2'd0, 32'h00000000, 4'h0, 1, "zero_mixed");

    run(1, 32'h3C00, 32'h3C00, 0, 2'd0, 32'h4000, 4'h0, 2, "h_one_plus_one");
    run(1, 32'h7BFF, 32'h7BFF, 0, 2'd0, 32'h7C00, 4'h5, 1, "h_ovf_rne");

    // abandon an op mid-flight with reset
    @(negedge clk);
    drive(1, 32'h3C00, 32'h4000, 0, 2'd0, 1'b1);
    n = 0;
    while (!iack16 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort/in_ack", {35'h0, iack16}, 36'h1);
    @(posedge clk);
    #1 stb16 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst16 = 1'b0;
    #1;
    chk("abort/outputs", {18'h0, iack16, zstb16, z16}, 36'h0);
    chk("abort/flags", {32'h0, f16}, 36'h0);
    @(negedge clk);
    rst16 = 1'b1;

    run(1, 32'h3C00, 32'h4000, 0, 2'd0, 32'h4200, 4'h0, 1, "h_after_reset");

    repeat (5) @(negedge clk);
    chk("drain", {4'h0, 32'(q32.size() + q16.size())}, 36'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
